// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the parameterised stream multiplexer family.
package stream_mux_pkg;

   localparam int unsigned MAX_CH = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // One-hot decode of a channel select; out-of-range selects decode to zero.
   function automatic logic [MAX_CH-1:0] onehot(input int unsigned sel, input int unsigned n);
      logic [MAX_CH-1:0] r;
      r = '0;
      if (sel < n) r = MAX_CH'(1) << sel;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// pointer advances past the granted channel whenever a transfer happens.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int unsigned N     = 4,
   localparam int unsigned SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             adv,
   input  logic [SEL_W-1:0] gnt_idx,
   output logic [N-1:0]     gnt
);

   logic [SEL_W-1:0] ptr_q;
   logic             found;
   int unsigned      idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr_q) + k) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (adv) begin
         ptr_q <= (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
   end

endmodule

// File: rtl/param_stream_mux.sv
// N-channel registered stream mux with a one-entry valid/ready output stage.
// Define MUX_RR_ARB_EN for round-robin arbitration; otherwise sel picks the channel.
module param_stream_mux
   import stream_mux_pkg::*;
#(
   parameter  int unsigned N     = 4,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_chan,
   output logic               out_valid,
   input  logic               out_ready
);

   state_e           state_q, state_d;
   logic [N-1:0]     gnt_c;
   logic [SEL_W-1:0] gnt_idx_c;
   logic [WIDTH-1:0] gnt_data_c;
   logic             can_load_c;
   logic             xfer_c;

`ifdef MUX_RR_ARB_EN
   logic unused_sel;
   assign unused_sel = ^sel;

   rr_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (in_valid),
      .adv     (xfer_c),
      .gnt_idx (gnt_idx_c),
      .gnt     (gnt_c)
   );
`else
   logic [MAX_CH-1:0] sel_oh_c;
   assign sel_oh_c = onehot(32'(sel), N);
   assign gnt_c    = sel_oh_c[N-1:0] & in_valid;
`endif

   // Grant encode and data select; grant is at most one-hot.
   always_comb begin
      gnt_idx_c  = '0;
      gnt_data_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt_c[i]) begin
            gnt_idx_c  = SEL_W'(i);
            gnt_data_c = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign can_load_c = (state_q == ST_EMPTY) || out_ready;
   assign in_ready   = (rst_n && can_load_c) ? gnt_c : '0;
   assign xfer_c     = |in_ready;
   assign out_valid  = (state_q == ST_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: if (xfer_c) state_d = ST_FULL;
         ST_FULL:  if (out_ready && !xfer_c) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Output word only changes on a load; a drain without reload keeps the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_chan <= '0;
      end else if (xfer_c) begin
         out_data <= gnt_data_c;
         out_chan <= gnt_idx_c;
      end
   end

endmodule

// File: tb/tb_param_stream_mux.sv
// Scoreboard bench for param_stream_mux (N=4, WIDTH=8); honours MUX_RR_ARB_EN.
module tb_param_stream_mux;

   localparam int unsigned N     = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned SEL_W = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [SEL_W-1:0]   sel;
   logic [WIDTH-1:0]   d [N];
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_chan;
   logic               out_valid;
   logic               out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected contents of the output register: {data, chan}, at most one entry.
   logic [WIDTH+SEL_W-1:0] q[$];
   int                     rr_ptr = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = d[i];
   end

   param_stream_mux #(.N(N), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: predicts the grant for the coming edge and queues the word.
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int           g;
      bit           full;
      exp_rdy = '0;
      g       = -1;
      if (!rst_n) begin
         q.delete();
         rr_ptr = 0;
         chk("in_ready_rst", 32'(in_ready), 32'(0));
      end else begin
         full = (q.size() != 0);
`ifdef MUX_RR_ARB_EN
         for (int k = 0; k < N; k++) begin
            int c;
            c = (rr_ptr + k) % N;
            if (g < 0 && in_valid[c]) g = c;
         end
`else
         if (int'(sel) < N && in_valid[sel]) g = int'(sel);
`endif
         if (!full || out_ready) begin
            if (g >= 0) exp_rdy[g] = 1'b1;
         end else begin
            g = -1;
         end
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         if (full && out_ready) void'(q.pop_front());
         if (g >= 0) begin
            q.push_back({d[g], SEL_W'(g)});
            rr_ptr = (g + 1) % N;
         end
      end
   end

   // Monitor: compares the output register against the expected entry after each edge.
   always @(posedge clk) begin
      #2;
      if (rst_n) begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0 && out_valid) begin
            chk("out_data", 32'(out_data), 32'(q[0][WIDTH+SEL_W-1:SEL_W]));
            chk("out_chan", 32'(out_chan), 32'(q[0][SEL_W-1:0]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      sel      = SEL_W'($urandom_range(0, N - 1));
      in_valid = N'($urandom);
      for (int i = 0; i < N; i++) d[i] = WIDTH'($urandom);
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      rand_inputs();

      // Reset with random inputs
      repeat (3) begin
         rand_inputs();
         out_ready = 1'($urandom);
         @(negedge clk);
         chk("rst_out_valid", 32'(out_valid), 32'(0));
         chk("rst_out_data", 32'(out_data), 32'(0));
         chk("rst_out_chan", 32'(out_chan), 32'(0));
         chk("rst_in_ready", 32'(in_ready), 32'(0));
      end
      in_valid = '0;
      cyc();
      rst_n = 1'b1;

      // Select sweep
      for (int i = 0; i < N; i++) d[i] = WIDTH'(8'h10 + i);
      in_valid  = 4'hF;
      out_ready = 1'b1;
      for (int s = 0; s < N; s++) begin
         sel = SEL_W'(s);
         cyc();
      end
      in_valid = '0;
      repeat (2) cyc();

      // Backpressure on a held word
      sel      = 2'd2;
      d[2]     = 8'hA5;
      in_valid = 4'b0100;
      cyc();
      out_ready = 1'b0;
      d[2]      = 8'h5A;
      repeat (5) cyc();
      out_ready = 1'b1;
      cyc();
      in_valid = '0;
      repeat (2) cyc();

      // Back-to-back on channel 1
      sel      = 2'd1;
      in_valid = 4'b0010;
      for (int k = 1; k <= 8; k++) begin
         d[1] = WIDTH'(k);
         cyc();
      end
      in_valid = '0;
      repeat (2) cyc();

`ifdef MUX_RR_ARB_EN
      // Round-robin fairness patterns
      in_valid = 4'hF;
      repeat (8) cyc();
      in_valid = 4'b1010;
      repeat (6) cyc();
      in_valid = '0;
      repeat (2) cyc();
`endif

      // Async reset during a stall
      sel      = 2'd0;
      d[0]     = 8'h33;
      in_valid = 4'b0001;
      cyc();
      out_ready = 1'b0;
      in_valid  = '0;
      repeat (2) cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'(0));
      chk("async_rst_data", 32'(out_data), 32'(0));
      repeat (2) cyc();
      rst_n = 1'b1;
      sel   = 2'd3;
      for (int i = 0; i < N; i++) d[i] = WIDTH'($urandom);
      in_valid  = 4'hF;
      out_ready = 1'b1;
      repeat (2) cyc();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      in_valid  = '0;
      out_ready = 1'b1;
      repeat (3) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
